// File: rtl/posit16_pack.sv
// Packs a posit16 from the regime string, exponent and fraction; round-to-nearest-even.
// 2-cycle valid/ready pipeline at 1 beat/clk; PACK_INEXACT_EN adds inexact flag and counter.
module posit16_pack #(
   parameter int ES     = 1,
   parameter int FRAC_W = 23
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           sign,
   input  logic [15:0]                    regbits,
   input  logic [((ES > 0) ? ES : 1)-1:0] exp_bits,
   input  logic [FRAC_W-1:0]              frac,
   input  logic                           is_zero,
   input  logic                           is_nar,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [15:0]                    posit
`ifdef PACK_INEXACT_EN
   ,
   output logic                           inexact,
   output logic [15:0]                    inexact_cnt
`endif
);

   localparam int BW = ES + FRAC_W;
   localparam int L  = 15 + BW;

   typedef struct packed {
      logic         sgn;
      logic         zero;
      logic         nar;
      logic [L-1:0] w;
   } s1_t;

   logic        s1_vld_q, s2_vld_q;
   logic        s1_adv, s2_adv;
   s1_t         s1_d, s1_q;
   logic [15:0] posit_d, posit_q;
   logic        inexact_d, inexact_q;

   assign s2_adv    = !s2_vld_q || out_ready;
   assign s1_adv    = !s1_vld_q || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_vld_q;
   assign posit     = posit_q;

   // The regime generator never sets bit 15.
   assert property (@(posedge clk) disable iff (rst) in_valid |-> !regbits[15]);

   // ---------------- Stage 1: regime length and body placement ----------------
   logic [14:0]   run_x;
   logic [3:0]    run_n;
   logic [3:0]    reg_len;
   logic [BW-1:0] body;

   always_comb begin
      run_x = regbits[14:0] ^ {15{regbits[14]}};
      run_n = 4'd15;
      // Ascending scan: the highest differing bit wins, giving the run length.
      for (int i = 0; i <= 14; i++) begin
         if (run_x[i]) run_n = 4'(14 - i);
      end
   end

   assign reg_len = (run_n == 4'd15) ? 4'd15 : run_n + 4'd1;

   generate
      if (ES > 0) begin : g_exp
         assign body = {exp_bits, frac};
      end else begin : g_noexp
         assign body = frac;
      end
   endgenerate

   always_comb begin
      s1_d      = '0;
      s1_d.sgn  = sign;
      s1_d.zero = is_zero;
      s1_d.nar  = is_nar;
      s1_d.w    = {regbits[14:0], {BW{1'b0}}} | ({body, 15'b0} >> reg_len);
   end

   // ---------------- Stage 2: rounding, clamps, sign, specials ----------------
   logic [14:0] mag, mag_r, mag_f;
   logic        g_bit, s_bit, at_max, rnd_up, clamp_min;
   logic [15:0] mag_ext, signed_val;

   always_comb begin
      mag        = s1_q.w[L-1 -: 15];
      g_bit      = s1_q.w[L-16];
      s_bit      = |s1_q.w[L-17:0];
      at_max     = &mag;
      rnd_up     = g_bit && (mag[0] || s_bit) && !at_max;
      mag_r      = mag + {14'b0, rnd_up};
      clamp_min  = (mag_r == 15'd0) && !s1_q.zero;
      mag_f      = clamp_min ? 15'd1 : mag_r;
      mag_ext    = {1'b0, mag_f};
      signed_val = s1_q.sgn ? (~mag_ext + 16'd1) : mag_ext;

      posit_d    = signed_val;
      inexact_d  = g_bit || s_bit || clamp_min;
      if (s1_q.nar) begin
         posit_d   = 16'h8000;
         inexact_d = 1'b0;
      end else if (s1_q.zero) begin
         posit_d   = 16'h0000;
         inexact_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_q      <= '0;
         s2_vld_q  <= 1'b0;
         posit_q   <= 16'h0000;
         inexact_q <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_vld_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
         end
         if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               posit_q   <= posit_d;
               inexact_q <= inexact_d;
            end
         end
      end
   end

`ifdef PACK_INEXACT_EN
   logic [15:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (s2_vld_q && out_ready && inexact_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 16'h0000;
      else     cnt_q <= cnt_d;
   end

   assign inexact     = inexact_q;
   assign inexact_cnt = cnt_q;
`else
   logic unused_inexact;
   assign unused_inexact = inexact_q;
`endif

endmodule

// File: tb/tb_posit16_pack.sv
// Directed vector table plus backpressure and mid-flight reset sequences for posit16_pack.
module tb_posit16_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic        sign;
   logic [15:0] regbits;
   logic [0:0]  exp_bits;
   logic [22:0] frac;
   logic        is_zero, is_nar;
   logic        out_valid, out_ready;
   logic [15:0] posit;
`ifdef PACK_INEXACT_EN
   logic        inexact;
   logic [15:0] inexact_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   posit16_pack #(.ES(1), .FRAC_W(23)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .sign(sign), .regbits(regbits), .exp_bits(exp_bits), .frac(frac),
      .is_zero(is_zero), .is_nar(is_nar),
      .out_valid(out_valid), .out_ready(out_ready), .posit(posit)
`ifdef PACK_INEXACT_EN
      , .inexact(inexact), .inexact_cnt(inexact_cnt)
`endif
   );

   typedef struct {
      logic        sgn;
      logic [15:0] rb;
      logic        ex;
      logic [22:0] fr;
      logic        z;
      logic        n;
      logic [15:0] exp_p;
      logic        exp_x;
   } vec_t;

   vec_t tv[15];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   task automatic drive(input int idx);
      sign     = tv[idx].sgn;
      regbits  = tv[idx].rb;
      exp_bits = tv[idx].ex;
      frac     = tv[idx].fr;
      is_zero  = tv[idx].z;
      is_nar   = tv[idx].n;
   endtask

   task automatic send(input int idx);
      int budget;
      @(negedge clk);
      drive(idx);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      budget    = 0;
      #1;
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         #1;
         budget++;
      end
      check($sformatf("vec%0d_in_ready", idx), 16'(in_ready), 16'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1_valid", idx), 16'(out_valid), 16'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_lat2_valid", idx), 16'(out_valid), 16'd1);
      check($sformatf("vec%0d_posit", idx), posit, tv[idx].exp_p);
`ifdef PACK_INEXACT_EN
      check($sformatf("vec%0d_inexact", idx), 16'(inexact), 16'(tv[idx].exp_x));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] got[$];
      logic        acc;
      int          stale;
      int          exp_inex;

      //        sgn  regbits   ex  frac        z  n  posit     inexact
      tv[0]  = '{0, 16'h4000, 0, 23'h000000, 0, 0, 16'h4000, 0};
      tv[1]  = '{1, 16'h4000, 0, 23'h000000, 0, 0, 16'hC000, 0};
      tv[2]  = '{0, 16'h4000, 0, 23'h400000, 0, 0, 16'h4800, 0};
      tv[3]  = '{0, 16'h2000, 0, 23'h000000, 0, 0, 16'h2000, 0};
      tv[4]  = '{0, 16'h4000, 0, 23'h7FFC00, 0, 0, 16'h5000, 1};
      tv[5]  = '{0, 16'h4000, 0, 23'h7FF400, 0, 0, 16'h4FFE, 1};
      tv[6]  = '{0, 16'h7FFF, 1, 23'h7FFFFF, 0, 0, 16'h7FFF, 1};
      tv[7]  = '{0, 16'h0000, 0, 23'h000001, 0, 0, 16'h0001, 1};
      tv[8]  = '{1, 16'h7FFF, 1, 23'h7FFFFF, 0, 0, 16'h8001, 1};
      tv[9]  = '{1, 16'h0000, 0, 23'h000001, 0, 0, 16'hFFFF, 1};
      tv[10] = '{0, 16'h4000, 0, 23'h000000, 1, 1, 16'h8000, 0};
      tv[11] = '{1, 16'h4000, 0, 23'h000000, 1, 0, 16'h0000, 0};
      tv[12] = '{0, 16'h6000, 1, 23'h200000, 0, 0, 16'h6A00, 0};
      tv[13] = '{0, 16'h1000, 1, 23'h7FFFFF, 0, 0, 16'h2000, 1};
      tv[14] = '{1, 16'h7FFF, 1, 23'h000000, 0, 1, 16'h8000, 0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive(0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 16'(out_valid), 16'd0);
      check("reset_posit", posit, 16'h0000);
      check("reset_in_ready", 16'(in_ready), 16'd1);
      @(negedge clk);
      rst = 1'b0;

      exp_inex = 0;
      for (int i = 0; i < 15; i++) begin
         send(i);
         if (tv[i].exp_x) exp_inex++;
      end
      @(posedge clk);
      #1;
`ifdef PACK_INEXACT_EN
      check("inexact_cnt", inexact_cnt, 16'(exp_inex));
`endif

      // Backpressure: three beats offered while the sink is stalled.
      @(negedge clk);
      out_ready = 1'b0;
      drive(0);
      in_valid = 1'b1;
      #1;
      check("bp_in_ready_beat0", 16'(in_ready), 16'd1);
      @(posedge clk);
      #1;
      drive(2);
      #1;
      check("bp_in_ready_beat1", 16'(in_ready), 16'd1);
      @(posedge clk);
      #1;
      drive(3);
      #1;
      check("bp_in_ready_full", 16'(in_ready), 16'd0);
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_posit_head", posit, 16'h4000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_posit", k), posit, 16'h4000);
         check($sformatf("bp_hold%0d_in_ready", k), 16'(in_ready), 16'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (out_valid) got.push_back(posit);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
         @(negedge clk);
      end
      check("bp_count", 16'(got.size()), 16'd3);
      if (got.size() == 3) begin
         check("bp_order0", got[0], 16'h4000);
         check("bp_order1", got[1], 16'h4800);
         check("bp_order2", got[2], 16'h2000);
      end

      // Reset with two beats in flight.
      out_ready = 1'b0;
      drive(4);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      drive(5);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("rst_pre_out_valid", 16'(out_valid), 16'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_posit", posit, 16'h0000);
      check("rst_in_ready", 16'(in_ready), 16'd1);
`ifdef PACK_INEXACT_EN
      check("rst_inexact_cnt", inexact_cnt, 16'h0000);
`endif
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      stale     = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("rst_no_stale", 16'(stale), 16'd0);
      send(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/posit16_pack.md
Name: posit16_pack

Overview:
- Downstream neighbour of the regime generator in the float→posit16 conversion path.
- Consumes the 16-bit regime bitstring plus the sign, the posit exponent bits and the float fraction.
- Derives the regime length, packs the exponent and fraction behind the regime, rounds to nearest-even and applies two's-complement sign.
- 2-stage valid/ready pipeline; stalls cleanly under backpressure.

Parameters:
- ES, 1, posit exponent field width (0..3)
- FRAC_W, 23, incoming fraction width (hidden bit excluded)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- sign  in  1  value sign
- regbits  in  16  regime string; bit15 always 0; regime left-aligned at bit14
- exp_bits  in  max(ES,1)  posit exponent field (ignored when ES=0)
- frac  in  FRAC_W  fraction, MSB first
- is_zero  in  1  input is zero
- is_nar  in  1  input is NaN/Inf
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- posit  out  16  packed posit16

Behaviour:
- Reset values: out_valid=0, posit=0x0000, both stage-valid flags 0. in_ready is combinational; it reads 1 while in reset.
- Reset asserted mid-operation discards all in-flight beats. No output is produced for them.
- Handshake:
  - A beat transfers when valid&ready are both high.
  - Stage n advances when it is empty or stage n+1 advances.
  - in_ready = !s1_valid | s2_advance.
  - out_valid = s2_valid. posit is held stable while out_valid&!out_ready.
  - Throughput is 1 beat/clk. Latency is 2 clk from input accept to out_valid.
  - A simultaneous accept on input and output in the same cycle is legal.
- Stage 1 (regime length):
  - r = regbits[14]; n = count of consecutive bits equal to r, starting at bit14 and going down.
  - reg_len = n+1 if n<15, else 15 (no terminator).
  - body = {exp_bits, frac} (ES+FRAC_W bits).
  - Wide word W (15+ES+FRAC_W bits) = {regbits[14:0], zeros} OR (body placed immediately after the first reg_len bits).
  - Register W, sign, is_zero and is_nar.
- Stage 2 (rounding):
  - mag = W top 15 bits; g = next bit; s = OR of remaining bits.
  - Round up iff g & (mag[0] | s).
  - If mag=0x7FFF, rounding up is suppressed: saturate at maxpos, never wrap to NaR.
  - If the result magnitude is 0 and the input is non-zero, force it to 0x0001 (minpos).
  - posit = sign ? -{1'b0,mag'} : {1'b0,mag'}, using 16-bit two's complement.
- Specials: is_nar → 0x8000. Otherwise is_zero → 0x0000. is_nar has priority. Sign is ignored for both.
- Width rule: all shifts are logical. reg_len is 4 bits unsigned.

Optional Feature:
- Macro: PACK_INEXACT_EN.
- When defined:
  - Adds output inexact (1 bit), valid with out_valid; set when g|s was nonzero or saturation/minpos clamping occurred. Specials give 0.
  - Adds output inexact_cnt (16 bits), a saturating count of inexact beats transferred out (out_valid&out_ready). It stops at 0xFFFF and resets to 0.
- When undefined: both ports and the counter are absent; all other behaviour is identical.

Test Plan:
- 1.0: regbits=0x4000, exp_bits=0, frac=0, sign=0 → posit=0x4000 exactly 2 clk after accept. Same inputs with sign=1 → 0xC000.
- Fraction and negative regime:
  - regbits=0x4000, exp=0, frac=0x400000 → 0x4800.
  - regbits=0x2000, exp=0, frac=0 → 0x2000.
- RNE tie: regbits=0x4000, exp=0, frac=0x7FFC00 → 0x5000. With frac=0x7FF400 (lsb 0 tie) → 0x4FFE.
- Clamps:
  - regbits=0x7FFF, exp=1, frac=0x7FFFFF → 0x7FFF; inexact=1 when enabled.
  - regbits=0x0000, exp=0, frac=0x000001 → 0x0001.
  - Both with sign=1 → 0x8001 / 0xFFFF.
- Specials: is_nar=1, is_zero=1 → 0x8000. is_zero=1, sign=1 → 0x0000.
- Backpressure and reset:
  - Hold out_ready=0 and offer 3 beats back-to-back. in_ready drops after 2 are accepted and output stays stable. Release → 3 results appear in order with no loss or duplication.
  - Assert rst with 2 beats in flight → out_valid=0 immediately, no stale output afterwards.
